// File: rtl/alu_seq.sv
// alu_seq -- registered, handshaked ALU with an iterative shift-add multiplier.
//
// Non-MUL opcodes are evaluated combinationally from the presented operands
// and loaded into the output register on the accept edge. MUL captures its
// operands on accept and runs one multiplier bit per cycle (LSB first) for
// WIDTH cycles before loading the double-width product.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand-issue handshake (in_ready is combinational)
//   x, y, sel           operands and opcode; y[SHW-1:0] is the shift amount
//   out_valid, out_ready result handshake
//   result, result_hi   result (low half for MUL), MUL upper half (else 0)
//   zero, carry, overflow, negative  registered flags
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,
                           OP_AND  = 4'd3,  OP_OR   = 4'd4,  OP_XOR  = 4'd5,
                           OP_XNOR = 4'd6,  OP_NOT  = 4'd7,  OP_NAND = 4'd8,
                           OP_NOR  = 4'd9,  OP_SLT  = 4'd10, OP_SLL  = 4'd11,
                           OP_SRL  = 4'd12, OP_ROL  = 4'd13, OP_ROR  = 4'd14,
                           OP_SRA  = 4'd15;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } alu_res_t;

    // Single-cycle operations. MUL is handled by the iterative path.
    function automatic alu_res_t alu_op(input logic [3:0] op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        alu_res_t                o;
        logic [WIDTH:0]          ext;
        logic signed [WIDTH:0]   sext;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          amt;
        logic [SHW-1:0]          idx;
        o    = '0;
        ext  = '0;
        sext = '0;
        sa   = $signed(a);
        sb   = $signed(b);
        amt  = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                o.r = ext[WIDTH-1:0];
                o.c = ext[WIDTH];
                o.v = (a[WIDTH-1] == b[WIDTH-1]) && (o.r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                ext = {1'b0, a} - {1'b0, b};
                o.r = ext[WIDTH-1:0];
                o.c = ext[WIDTH];
                o.v = (a[WIDTH-1] != b[WIDTH-1]) && (o.r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  o.r = a & b;
            OP_OR:   o.r = a | b;
            OP_XOR:  o.r = a ^ b;
            OP_XNOR: o.r = ~(a ^ b);
            OP_NOT:  o.r = ~a;
            OP_NAND: o.r = ~(a & b);
            OP_NOR:  o.r = ~(a | b);
            OP_SLT:  o.r = WIDTH'(sa < sb);
            // A guard bit beside the operand catches the last bit shifted out;
            // with a zero amount the guard stays 0.
            OP_SLL:  {o.c, o.r} = {1'b0, a} << amt;
            OP_SRL:  {o.r, o.c} = {a, 1'b0} >> amt;
            OP_SRA: begin
                sext = $signed({a, 1'b0}) >>> amt;
                {o.r, o.c} = sext;
            end
            // Index arithmetic wraps modulo WIDTH because WIDTH is a power of two.
            OP_ROL: begin
                for (int i = 0; i < WIDTH; i++) begin
                    idx = SHW'(i) - amt;
                    o.r[i] = a[idx];
                end
            end
            OP_ROR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    idx = SHW'(i) + amt;
                    o.r[i] = a[idx];
                end
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 neg_q, neg_d;
    alu_res_t             alu_res;
    logic                 accept;

    assign alu_res  = alu_op(sel, x, y);
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;

        // Drain first; a load later in this block overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sel == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, x};
                        mplier_d = y;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = alu_res.r;
                        hi_d        = '0;
                        zero_d      = (alu_res.r == '0);
                        carry_d     = alu_res.c;
                        ovf_d       = alu_res.v;
                        neg_d       = alu_res.r[WIDTH-1];
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    // Final partial product is folded in on the loading edge.
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    res_d       = acc_d[WIDTH-1:0];
                    hi_d        = acc_d[2*WIDTH-1:WIDTH];
                    zero_d      = (acc_d == '0);
                    carry_d     = (acc_d[2*WIDTH-1:WIDTH] != '0);
                    ovf_d       = (acc_d[2*WIDTH-1:WIDTH] != '0);
                    neg_d       = acc_d[WIDTH-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_seq;
    localparam int W = 8;
    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,
                           OP_AND  = 4'd3,  OP_OR   = 4'd4,  OP_XOR  = 4'd5,
                           OP_XNOR = 4'd6,  OP_NOT  = 4'd7,  OP_NAND = 4'd8,
                           OP_NOR  = 4'd9,  OP_SLT  = 4'd10, OP_SLL  = 4'd11,
                           OP_SRL  = 4'd12, OP_ROL  = 4'd13, OP_ROR  = 4'd14,
                           OP_SRA  = 4'd15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [3:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result, result_hi;
    logic         zero, carry, overflow, negative;

    // flags field is {zero, carry, overflow, negative}
    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic [3:0]   f;
        int           tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
        .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] er, input logic [W-1:0] ehi,
                            input logic [3:0] ef, input int tag);
        exp_t e;
        e.r = er; e.hi = ehi; e.f = ef; e.tag = tag;
        sb.push_back(e);
    endtask

    // Present an op, wait (bounded) for acceptance, then scramble the inputs.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic [W-1:0] er, input logic [W-1:0] ehi,
                        input logic [3:0] ef, input int tag);
        int n;
        in_valid = 1'b1; sel = op; x = a; y = b; n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout tag %0d", tag);
        end
        if (push) push_exp(er, ehi, ef, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = W'($urandom); y = W'($urandom); sel = 4'($urandom);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_output: got %h with no expected entry", result);
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d", e.tag),
                      {12'h0, result, result_hi, zero, carry, overflow, negative},
                      {12'h0, e.r, e.hi, e.f});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, low;
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {out_valid, result, result_hi, zero, carry, overflow, negative}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Streaming single-cycle ops, out_ready held high
        send(OP_ADD,  8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'b0011, 1);
        send(OP_SUB,  8'h00, 8'h01, 1, 8'hFF, 8'h00, 4'b0101, 2);
        send(OP_SUB,  8'h05, 8'h05, 1, 8'h00, 8'h00, 4'b1000, 3);
        send(OP_AND,  8'hF0, 8'h3C, 1, 8'h30, 8'h00, 4'b0000, 4);
        send(OP_OR,   8'hF0, 8'h0F, 1, 8'hFF, 8'h00, 4'b0001, 5);
        send(OP_XOR,  8'hAA, 8'hFF, 1, 8'h55, 8'h00, 4'b0000, 6);
        send(OP_XNOR, 8'hAA, 8'h0F, 1, 8'h5A, 8'h00, 4'b0000, 7);
        send(OP_NOT,  8'h0F, 8'h55, 1, 8'hF0, 8'h00, 4'b0001, 8);
        send(OP_NAND, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 4'b1000, 9);
        send(OP_NOR,  8'h00, 8'h00, 1, 8'hFF, 8'h00, 4'b0001, 10);
        send(OP_SLT,  8'h80, 8'h01, 1, 8'h01, 8'h00, 4'b0000, 11);
        send(OP_SLT,  8'h01, 8'h80, 1, 8'h00, 8'h00, 4'b1000, 12);
        send(OP_SLL,  8'h81, 8'h01, 1, 8'h02, 8'h00, 4'b0100, 13);
        send(OP_SRL,  8'h81, 8'h01, 1, 8'h40, 8'h00, 4'b0100, 14);
        send(OP_SRL,  8'h81, 8'h08, 1, 8'h81, 8'h00, 4'b0001, 15);
        send(OP_SRA,  8'h80, 8'h03, 1, 8'hF0, 8'h00, 4'b0001, 16);
        send(OP_ROR,  8'h01, 8'h01, 1, 8'h80, 8'h00, 4'b0001, 17);
        send(OP_ROL,  8'h81, 8'h01, 1, 8'h03, 8'h00, 4'b0000, 18);
        send(OP_ADD,  8'hFF, 8'h01, 1, 8'h00, 8'h00, 4'b1100, 19);
        send(OP_SUB,  8'h80, 8'h01, 1, 8'h7F, 8'h00, 4'b0010, 20);
        send(OP_SLL,  8'h01, 8'h07, 1, 8'h80, 8'h00, 4'b0001, 21);
        send(OP_SRA,  8'h80, 8'h00, 1, 8'h80, 8'h00, 4'b0001, 22);

        // MUL: latency and busy window
        send(OP_MUL, 8'hFF, 8'hFF, 1, 8'h01, 8'hFE, 4'b0110, 30);
        k = 0; low = 0;
        do begin
            @(negedge clk);
            k++;
            if (!out_valid && !in_ready) low++;
        end while (!out_valid && k < 40);
        check("mul_latency", k - 1, 8);
        check("mul_busy_cycles", low, 8);
        @(posedge clk); #1;
        send(OP_MUL, 8'h00, 8'h37, 1, 8'h00, 8'h00, 4'b1000, 31);
        send(OP_MUL, 8'h0F, 8'h11, 1, 8'hFF, 8'h00, 4'b0001, 32);
        repeat (12) @(posedge clk);
        #1;

        // Backpressure
        out_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h02, 1, 8'h03, 8'h00, 4'b0000, 40);
        in_valid = 1'b1; sel = OP_ADD; x = 8'h03; y = 8'h04;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold", {out_valid, result, zero, carry, overflow, negative}, {1'b1, 8'h03, 4'b0000});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_exp(8'h07, 8'h00, 4'b0000, 41);
        @(negedge clk);
        check("bp_accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second", {out_valid, result}, {1'b1, 8'h07});
        @(posedge clk); #1;

        // Reset during MUL
        send(OP_MUL, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 4'b0000, 50);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_mul", {out_valid, result, result_hi, zero, carry, overflow, negative}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(OP_ADD, 8'h02, 8'h03, 1, 8'h05, 8'h00, 4'b0000, 51);

        repeat (12) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Datapath and output flags are registered.
- All operations except MUL complete in one cycle; MUL is an iterative shift-add over WIDTH cycles with a full double-width product.
- Shift/rotate amount comes from `y`; adds SRA and signed SLT; NOR is a true NOR.
- Sits between an operand-issue stage and a result consumer, both using valid/ready.

## Interface
- `WIDTH`, default 8: operand/result width; power of two, minimum 4.
- `SHW`, default $clog2(WIDTH): shift-amount width, derived; do not override.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operand/op presented.
- `in_ready` output 1: block accepts a new operation this cycle.
- `x` input WIDTH: operand A.
- `y` input WIDTH: operand B; `y[SHW-1:0]` is the shift amount for shift/rotate ops.
- `sel` input 4: opcode.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: result, low half for MUL.
- `result_hi` output WIDTH: MUL upper half; 0 for all other ops.
- `zero`, `carry`, `overflow`, `negative` output 1 each: flags.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (unsigned), 3 AND, 4 OR, 5 XOR, 6 XNOR, 7 NOT x, 8 NAND, 9 NOR.
  - 10 SLT (signed x<y gives 1, else 0).
  - 11 SLL, 12 SRL, 13 ROL, 14 ROR, 15 SRA (all by `y[SHW-1:0]`).
- FSM states:
  - IDLE → (accept, sel==MUL) → MUL.
  - IDLE → (accept, other op) → IDLE, result loaded into the output register.
  - MUL → (iteration count == WIDTH-1) → IDLE, result loaded.
- Accept is `in_valid && in_ready`.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). It is combinational and 0 throughout MUL.
- Output register:
  - Loads and sets `out_valid` on completion.
  - Holds all outputs stable while `out_valid && !out_ready`.
  - Clears `out_valid` on `out_valid && out_ready` unless a new load happens on the same edge (the load wins).
- Operands are captured at accept; `x`/`y`/`sel` changes afterwards have no effect.
- MUL: 2·WIDTH accumulator, one multiplier bit per cycle (LSB first).
- Flag rules:
  - `zero` = (result == 0); MUL uses both halves.
  - `negative` = `result[WIDTH-1]`.
  - ADD: `carry` = unsigned carry-out. `overflow` = operands share a sign and the result sign differs.
  - SUB: `carry` = borrow (x < y unsigned). `overflow` = operand signs differ and the result sign differs from x.
  - MUL: `carry` = `overflow` = (`result_hi` != 0).
  - SLL/SRL/SRA: `carry` = last bit shifted out; 0 when amount is 0. `overflow` = 0.
  - Logic ops, SLT, rotates: `carry` = `overflow` = 0.
- Reset while busy (including mid-MUL): abort, FSM to IDLE, in-flight op discarded.

## Timing
- Reset values:
  - `out_valid` = 0.
  - `result`, `result_hi` = 0.
  - All four flags = 0.
  - FSM = IDLE, iteration counter = 0.
  - `in_ready` = 1 once `rst_n` is high.
- Latency from the accept edge to `out_valid` high:
  - Non-MUL: 1 cycle.
  - MUL: WIDTH cycles.
- Throughput:
  - Non-MUL: one op per cycle while `out_ready` stays high.
  - MUL: one op per WIDTH+1 cycles minimum.
- Output drain with `out_ready` high: `in_ready` stays high, so back-to-back non-MUL ops stream.
- MUL completion: the output register is always empty or being drained, because MUL is accepted only under the `in_ready` condition.
- Reset assertion takes effect immediately (asynchronous). Release is synchronous to `clk`; the first accept is possible on the first edge after release.

## Test plan
- ADD 0x7F+0x01 (WIDTH=8), `out_ready`=1 → next cycle `result`=0x80, overflow=1, negative=1, carry=0, zero=0.
- SUB 0x00−0x01 → `result`=0xFF, carry=1, negative=1, overflow=0; SUB 0x05−0x05 → zero=1.
- MUL 0xFF×0xFF → `in_ready`=0 for 8 cycles, `out_valid` 8 cycles after accept, `result`=0x01, `result_hi`=0xFE, carry=overflow=1; MUL 0x00×0x37 → zero=1.
- Shifts (one op each):
  - SLL 0x81 by 1 → 0x02, carry=1.
  - SRA 0x80 by 3 → 0xF0, carry=0.
  - ROR 0x01 by 1 → 0x80.
  - SLT 0x80 vs 0x01 → 0x01.
- Backpressure: two ADDs issued with `out_ready`=0.
  - First result held stable; `in_ready`=0 and the second op is not accepted.
  - Raise `out_ready` → second accepted the same edge the first drains; second result appears next cycle.
- Assert `rst_n`=0 at MUL cycle 4 → all outputs 0 immediately. After release, `in_ready`=1 and a following ADD 2+3 returns 0x05.
